// File: rtl/edlo_fetch_seq.sv
// edlo_fetch_seq -- instruction fetch/sequencer feeding the EDLO ALU.
//
// Walks the program RAM from address 0, reading two-byte instructions
// (opcode byte, operand byte). ALU opcodes 0x0-0xD are issued over a
// valid/ready handshake; JMP (0xE) and HALT (0xF) are executed locally and
// are never forwarded.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            begins execution at address 0 (only from IDLE/HALTED)
//   halt_req         stop at the next instruction boundary
//   mem_addr         RAM read address (combinational)
//   mem_rdata        RAM read data, one cycle after mem_addr
//   alu_inst/operand registered instruction to the ALU
//   alu_valid        issue strobe, held until alu_ready
//   alu_ready        ALU accept
//   pc               address of the current opcode byte
//   running, halted  status
//   issue_count      accepted instructions, saturating at 255
module edlo_fetch_seq #(
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic [3:0]           alu_inst,
  output logic [7:0]           alu_operand,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 running,
  output logic                 halted,
  output logic [7:0]           issue_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_OP  = 3'd1,
    S_RD_ARG = 3'd2,
    S_DECODE = 3'd3,
    S_ISSUE  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [3:0] opcode_q;

  // The operand byte is read while in RD_ARG, so it lands in DECODE.
  always_comb begin
    mem_addr = pc;
    if (state == S_RD_ARG) mem_addr = pc + ADDR_BITS'(1);
  end

  assign running = (state != S_IDLE) && (state != S_HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      opcode_q    <= '0;
      alu_inst    <= '0;
      alu_operand <= '0;
      alu_valid   <= 1'b0;
      issue_count <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state       <= S_RD_OP;
            pc          <= '0;
            issue_count <= '0;
            halted      <= 1'b0;
          end
        end
        S_RD_OP: state <= S_RD_ARG;
        S_RD_ARG: begin
          opcode_q <= mem_rdata[7:4];
          state    <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode_q == OP_HALT) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (opcode_q == OP_JMP) begin
            pc <= mem_rdata[ADDR_BITS-1:0];
            if (halt_req) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_RD_OP;
            end
          end else begin
            alu_inst    <= opcode_q;
            alu_operand <= mem_rdata;
            alu_valid   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (alu_ready) begin
            alu_valid <= 1'b0;
            pc        <= pc + ADDR_BITS'(2);
            if (issue_count != 8'hFF) issue_count <= issue_count + 8'd1;
            if (halt_req) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_RD_OP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edlo_fetch_seq.sv
module tb_edlo_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, halt_req, alu_ready;
  logic [3:0] mem_addr, pc, alu_inst;
  logic [7:0] mem_rdata, alu_operand, issue_count;
  logic       alu_valid, running, halted;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edlo_fetch_seq #(.ADDR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .alu_inst(alu_inst), .alu_operand(alu_operand),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .pc(pc), .running(running), .halted(halted), .issue_count(issue_count)
  );

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; alu_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Issue-level reference model: interprets the program directly.
  logic [11:0] exp_q[$];
  bit          m_halted;
  logic [3:0]  m_pc;

  task automatic ref_model(input int max_iss);
    int p = 0;
    logic [3:0] op;
    logic [7:0] arg;
    exp_q.delete();
    m_halted = 1'b0;
    for (int s = 0; s < 200 && !m_halted && exp_q.size() < max_iss; s++) begin
      op  = mem[p][7:4];
      arg = mem[(p + 1) % 16];
      if (op == 4'hF) m_halted = 1'b1;
      else if (op == 4'hE) p = arg % 16;
      else begin
        exp_q.push_back({op, arg});
        p = (p + 2) % 16;
      end
    end
    m_pc = 4'(p);
  endtask

  // DUT driver: start pulse, then per-cycle handshake capture and hold checks.
  logic [11:0] got[$];
  int first_valid, last_acc, halt_cyc;

  task automatic run(input int stall, input bit rnd, input int max_iss, input int bound);
    int cyc;
    bit prev_hold;
    logic [11:0] hold_val;
    int st = stall;
    got.delete();
    first_valid = -1; last_acc = -1; halt_cyc = -1;
    halt_req = 1'b0; alu_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    prev_hold = 1'b0;
    hold_val = '0;
    for (cyc = 1; cyc <= bound; cyc++) begin
      if (prev_hold) begin
        check("hold_valid", 32'(alu_valid), 32'd1);
        check("hold_data", 32'({alu_inst, alu_operand}), 32'(hold_val));
      end
      if (halted) begin
        halt_cyc = cyc;
        break;
      end
      if (got.size() >= max_iss) break;
      if (alu_valid && first_valid < 0) first_valid = cyc;
      if (rnd) alu_ready = 1'($urandom_range(0, 1));
      else if (alu_valid && st > 0) begin
        alu_ready = 1'b0;
        st--;
      end else alu_ready = 1'b1;
      prev_hold = alu_valid && !alu_ready;
      hold_val  = {alu_inst, alu_operand};
      if (alu_valid && alu_ready) begin
        got.push_back({alu_inst, alu_operand});
        last_acc = cyc;
      end
      tick();
    end
    alu_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  prog [16];
    int          stall;
    int          first;
    int          n;
    logic [11:0] e0;
    logic [11:0] e1;
    logic [3:0]  pc;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int acc;
    bit ok;

    vecs[0] = '{prog: '{0:8'h30, 1:8'h05, 2:8'h10, 3:8'h07, 4:8'hF0, default:8'h00},
                stall: 0, first: 4, n: 2, e0: 12'h305, e1: 12'h107, pc: 4'd4, cnt: 8'd2};
    vecs[1] = '{prog: '{0:8'h30, 1:8'h05, 2:8'h10, 3:8'h07, 4:8'hF0, default:8'h00},
                stall: 5, first: 4, n: 2, e0: 12'h305, e1: 12'h107, pc: 4'd4, cnt: 8'd2};
    vecs[2] = '{prog: '{0:8'hE0, 1:8'h06, 2:8'h20, 3:8'hAA, 4:8'hF0, 6:8'h40, 7:8'h11,
                        8:8'hF0, default:8'h00},
                stall: 0, first: 7, n: 1, e0: 12'h411, e1: 12'h000, pc: 4'd8, cnt: 8'd1};

    clear_mem();
    do_reset();
    check("rst_valid", 32'(alu_valid), 0);
    check("rst_inst", 32'(alu_inst), 0);
    check("rst_operand", 32'(alu_operand), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_count", 32'(issue_count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);

    // Directed program vectors.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = vecs[k].prog[i];
      do_reset();
      run(vecs[k].stall, 1'b0, 8, 100);
      check($sformatf("v%0d_first_valid", k), 32'(first_valid), 32'(vecs[k].first));
      check($sformatf("v%0d_n_issues", k), 32'(got.size()), 32'(vecs[k].n));
      if (got.size() > 0) check($sformatf("v%0d_issue0", k), 32'(got[0]), 32'(vecs[k].e0));
      if (vecs[k].n > 1 && got.size() > 1)
        check($sformatf("v%0d_issue1", k), 32'(got[1]), 32'(vecs[k].e1));
      check($sformatf("v%0d_halted", k), 32'(halted), 1);
      check($sformatf("v%0d_pc", k), 32'(pc), 32'(vecs[k].pc));
      check($sformatf("v%0d_count", k), 32'(issue_count), 32'(vecs[k].cnt));
      check($sformatf("v%0d_halt_latency", k), 32'(halt_cyc - last_acc), 32'd4);
    end

    // Wrap: JMP to 14, ALU op at 14 takes its operand from 15, then pc wraps to 0.
    clear_mem();
    mem[0] = 8'hE0; mem[1] = 8'h0E; mem[14] = 8'h50; mem[15] = 8'h77;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;   // cycle 1
    tick(); tick(); tick();               // cycle 4: RD_OP at 14
    check("wrap_pc14", 32'(pc), 32'd14);
    start = 1'b1;                         // ignored while running
    tick(); start = 1'b0;                 // cycle 5: RD_ARG
    check("wrap_mem_addr15", 32'(mem_addr), 32'd15);
    check("wrap_start_ignored", 32'(pc), 32'd14);
    tick(); tick();                       // cycle 7: ISSUE
    check("wrap_valid", 32'(alu_valid), 1);
    check("wrap_issue", 32'({alu_inst, alu_operand}), 32'h577);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    check("wrap_pc0", 32'(pc), 0);
    check("wrap_mem_addr0", 32'(mem_addr), 0);
    check("wrap_count", 32'(issue_count), 1);
    halt_req = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      ok = halted;
    end
    halt_req = 1'b0;
    check("wrap_jmp_halt", 32'(ok), 1);
    check("wrap_jmp_halt_pc", 32'(pc), 32'd14);

    // halt_req during a stalled issue: instruction completes, then HALTED; restart.
    for (int i = 0; i < 16; i++) mem[i] = vecs[0].prog[i];
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      ok = alu_valid;
      if (!ok) tick();
    end
    check("hreq_valid_seen", 32'(ok), 1);
    halt_req = 1'b1;
    tick(); tick();
    check("hreq_still_valid", 32'(alu_valid), 1);
    check("hreq_still_inst", 32'({alu_inst, alu_operand}), 32'h305);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0; halt_req = 1'b0;
    check("hreq_halted", 32'(halted), 1);
    check("hreq_running", 32'(running), 0);
    check("hreq_valid_clr", 32'(alu_valid), 0);
    check("hreq_count", 32'(issue_count), 1);
    check("hreq_pc", 32'(pc), 2);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_halted", 32'(halted), 0);
    check("restart_running", 32'(running), 1);
    check("restart_pc", 32'(pc), 0);
    check("restart_count", 32'(issue_count), 0);
    alu_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      ok = halted;
    end
    alu_ready = 1'b0;
    check("restart_done", 32'(ok), 1);
    check("restart_final_count", 32'(issue_count), 2);
    check("restart_final_pc", 32'(pc), 4);

    // Reset in the middle of a handshake.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("midrst_valid_before", 32'(alu_valid), 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("midrst_valid", 32'(alu_valid), 0);
    check("midrst_running", 32'(running), 0);
    check("midrst_pc", 32'(pc), 0);
    check("midrst_count", 32'(issue_count), 0);
    check("midrst_inst", 32'({alu_inst, alu_operand}), 0);

    // Saturation: 300 issues through a JMP-back loop.
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h01; mem[2] = 8'hE0; mem[3] = 8'h00;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    alu_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 3000 && acc < 300; c++) begin
      if (alu_valid) acc++;
      tick();
    end
    check("sat_accepts", 32'(acc), 32'd300);
    check("sat_count", 32'(issue_count), 32'd255);
    halt_req = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      ok = halted;
    end
    halt_req = 1'b0; alu_ready = 1'b0;
    check("sat_halt", 32'(ok), 1);
    check("sat_count_final", 32'(issue_count), 32'd255);

    // Random programs with random ready against the interpreter model.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) begin
        int r = $urandom_range(0, 7);
        logic [3:0] hi = (r == 0) ? 4'hF : (r == 1) ? 4'hE : 4'($urandom_range(0, 13));
        mem[i] = {hi, 4'($urandom_range(0, 15))};
      end
      ref_model(30);
      do_reset();
      run(0, 1'b1, 30, 800);
      check($sformatf("rnd%0d_n", t), 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
        check($sformatf("rnd%0d_issue%0d", t, i), 32'(got[i]), 32'(exp_q[i]));
      check($sformatf("rnd%0d_halted", t), 32'(halted), 32'(m_halted));
      if (m_halted) begin
        check($sformatf("rnd%0d_pc", t), 32'(pc), 32'(m_pc));
        check($sformatf("rnd%0d_count", t), 32'(issue_count), 32'(exp_q.size()));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
